wcc_update_packer: RTL and testbench

WCC_UPDATE_PACKER -- requirements
Module: wcc_update_packer

---
 rtl/wcc_pkg.sv | 40 ++++
 rtl/wcc_update_packer_if.sv | 32 +++
 rtl/wcc_pack_beat_reg.sv | 53 +++++
 rtl/wcc_update_packer.sv | 162 ++++++++++++++++
 tb/tb_wcc_update_packer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wcc_pkg.sv
// Shared types and constants for the WCC scatter-update packer.
// Update word layout: value in the upper 32 bits, destination in the lower 32 bits.
package wcc_pkg;

    localparam int unsigned WCC_LANES = 8;
    localparam int unsigned WCC_UPD_W = 64;
    localparam int unsigned WCC_CNT_W = 32;

    localparam int unsigned VAL_LSB  = 32;
    localparam int unsigned VAL_W    = 32;
    localparam int unsigned DEST_LSB = 0;
    localparam int unsigned DEST_W   = 32;

    // Filler for lanes that carry no update
    localparam logic [63:0] PAD_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        WCC_FILL  = 2'd0,
        WCC_FLUSH = 2'd1,
        WCC_DONE  = 2'd2
    } wcc_state_e;

    localparam logic [1:0] ST_FILL  = WCC_FILL;
    localparam logic [1:0] ST_FLUSH = WCC_FLUSH;
    localparam logic [1:0] ST_DONE  = WCC_DONE;

    typedef struct packed {
        logic [VAL_W-1:0]  value;
        logic [DEST_W-1:0] dest;
    } wcc_upd_t;

    function automatic logic [DEST_W-1:0] upd_dest(input logic [WCC_UPD_W-1:0] w);
        return w[DEST_LSB +: DEST_W];
    endfunction

    function automatic logic [VAL_W-1:0] upd_val(input logic [WCC_UPD_W-1:0] w);
        return w[VAL_LSB +: VAL_W];
    endfunction

endpackage

// File: rtl/wcc_update_packer_if.sv
// Update stream, flush control and packed-beat stream of the WCC packer.
// slave = packer side, master = pipe/downstream side.
interface wcc_update_packer_if
    import wcc_pkg::*;
#(
    parameter int unsigned LANES = WCC_LANES,
    parameter int unsigned UPD_W = WCC_UPD_W,
    parameter int unsigned CNT_W = WCC_CNT_W
);

    logic [UPD_W-1:0]       update_word;
    logic                   update_valid;
    logic                   update_ready;
    logic                   flush;
    logic                   flush_done;
    logic [LANES*UPD_W-1:0] out_word;
    logic [LANES-1:0]       out_lane_mask;
    logic                   out_valid;
    logic                   out_ready;
    logic [CNT_W-1:0]       upd_count;

    modport slave (
        input  update_word, update_valid, flush, out_ready,
        output update_ready, flush_done, out_word, out_lane_mask, out_valid, upd_count
    );

    modport master (
        output update_word, update_valid, flush, out_ready,
        input  update_ready, flush_done, out_word, out_lane_mask, out_valid, upd_count
    );

endinterface

// File: rtl/wcc_pack_beat_reg.sv
// Output beat register: holds one packed beat until downstream takes it.
// A load always wins over a take, so a beat can be replaced in the cycle it leaves.
module wcc_pack_beat_reg
    import wcc_pkg::*;
#(
    parameter int unsigned LANES = WCC_LANES,
    parameter int unsigned UPD_W = WCC_UPD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [LANES*UPD_W-1:0] word_i,
    input  logic [LANES-1:0]       mask_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [LANES*UPD_W-1:0] word_o,
    output logic [LANES-1:0]       mask_o
);

    logic                   valid_q, valid_d;
    logic [LANES*UPD_W-1:0] word_q, word_d;
    logic [LANES-1:0]       mask_q, mask_d;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        mask_d  = mask_q;
        if (load_i) begin
            valid_d = 1'b1;
            word_d  = word_i;
            mask_d  = mask_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            word_q  <= {LANES{UPD_W'(PAD_WORD)}};
            mask_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign mask_o  = mask_q;

endmodule

// File: rtl/wcc_update_packer.sv
// Packs WCC scatter updates into LANES-wide beats; flush drains a partial beat.
// Optional: define WCC_PACK_COALESCE_EN to merge back-to-back updates to the same dest (min value).
module wcc_update_packer
    import wcc_pkg::*;
#(
    parameter int unsigned LANES = WCC_LANES,
    parameter int unsigned UPD_W = WCC_UPD_W,
    parameter int unsigned CNT_W = WCC_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    wcc_update_packer_if.slave bus
);

    localparam int unsigned CNT_IW = $clog2(LANES + 1);
    localparam int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

    logic [1:0]        state_q, state_d;
    logic [CNT_IW-1:0] cnt_q, cnt_d;
    logic [UPD_W-1:0]  buf_q [LANES];
    logic [UPD_W-1:0]  buf_d [LANES];
    logic [CNT_W-1:0]  upd_cnt_q, upd_cnt_d;
    logic              flush_done_q, flush_done_d;
    logic              run_q;

    logic                   o_valid;
    logic [LANES*UPD_W-1:0] o_word;
    logic [LANES-1:0]       o_mask;

    logic                   full_c;
    logic                   o_free_c;
    logic                   transfer_c;
    logic                   ready_c;
    logic                   accept_c;
    logic [IDX_W-1:0]       idx_c;
    logic [LANES*UPD_W-1:0] beat_word_c;
    logic [LANES-1:0]       beat_mask_c;

    assign full_c     = (cnt_q == CNT_IW'(LANES));
    assign o_free_c   = !o_valid || bus.out_ready;
    assign transfer_c = (full_c || ((state_q == ST_FLUSH) && (cnt_q != '0))) && o_free_c;
    // run_q keeps ready low during reset and for the first edge after release
    assign ready_c    = run_q && (state_q == ST_FILL) && (!full_c || transfer_c);
    assign accept_c   = bus.update_valid && ready_c;
    assign idx_c      = IDX_W'(cnt_q);

    // Beat image of the assembly buffer: filled lanes first, the rest padded
    always_comb begin
        beat_word_c = {LANES{UPD_W'(PAD_WORD)}};
        beat_mask_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (CNT_IW'(i) < cnt_q) begin
                beat_word_c[i*UPD_W +: UPD_W] = buf_q[i];
                beat_mask_c[i]                = 1'b1;
            end
        end
    end

`ifdef WCC_PACK_COALESCE_EN
    logic [IDX_W-1:0] idx_last_c;
    logic             same_dest_c;

    assign idx_last_c  = IDX_W'(cnt_q - CNT_IW'(1));
    assign same_dest_c = (cnt_q != '0) &&
                         (buf_q[idx_last_c][DEST_LSB +: DEST_W] == bus.update_word[DEST_LSB +: DEST_W]);
`endif

    // Assembly buffer next state
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (transfer_c) begin
            cnt_d = accept_c ? CNT_IW'(1) : '0;
            if (accept_c) begin
                buf_d[0] = bus.update_word;
            end
        end else if (accept_c) begin
`ifdef WCC_PACK_COALESCE_EN
            if (same_dest_c) begin
                if (bus.update_word[VAL_LSB +: VAL_W] < buf_q[idx_last_c][VAL_LSB +: VAL_W]) begin
                    buf_d[idx_last_c][VAL_LSB +: VAL_W] = bus.update_word[VAL_LSB +: VAL_W];
                end
            end else begin
                buf_d[idx_c] = bus.update_word;
                cnt_d        = cnt_q + CNT_IW'(1);
            end
`else
            buf_d[idx_c] = bus.update_word;
            cnt_d        = cnt_q + CNT_IW'(1);
`endif
        end
    end

    // Flush sequencing and accepted-update counter
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        upd_cnt_d    = upd_cnt_q;
        case (state_q)
            ST_FILL: begin
                if (bus.flush) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if ((cnt_q == '0) && o_free_c) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_FILL;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        flush_done_d = (state_d == ST_DONE);
        if (accept_c && (upd_cnt_q != '1)) begin
            upd_cnt_d = upd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FILL;
            cnt_q        <= '0;
            upd_cnt_q    <= '0;
            flush_done_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            upd_cnt_q    <= upd_cnt_d;
            flush_done_q <= flush_done_d;
            run_q        <= 1'b1;
        end
    end

    // Lane storage needs no reset: cnt_q alone decides which lanes are live
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    wcc_pack_beat_reg #(
        .LANES (LANES),
        .UPD_W (UPD_W)
    ) u_beat (
        .clk     (clk),
        .rst     (rst),
        .load_i  (transfer_c),
        .word_i  (beat_word_c),
        .mask_i  (beat_mask_c),
        .ready_i (bus.out_ready),
        .valid_o (o_valid),
        .word_o  (o_word),
        .mask_o  (o_mask)
    );

    assign bus.update_ready  = ready_c;
    assign bus.flush_done    = flush_done_q;
    assign bus.out_valid     = o_valid;
    assign bus.out_word      = o_word;
    assign bus.out_lane_mask = o_mask;
    assign bus.upd_count     = upd_cnt_q;

endmodule

// File: tb/tb_wcc_update_packer.sv
// Scoreboard bench for wcc_update_packer: directed scenarios plus random traffic.
module tb_wcc_update_packer;
    import wcc_pkg::*;

    localparam int unsigned LANES = 8;
    localparam int unsigned UPD_W = 64;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned BW    = LANES * UPD_W;

    typedef struct {
        logic [BW-1:0]    word;
        logic [LANES-1:0] mask;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wcc_update_packer_if #(.LANES(LANES), .UPD_W(UPD_W), .CNT_W(CNT_W)) bus ();

    wcc_update_packer #(.LANES(LANES), .UPD_W(UPD_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    beat_t            exp_q[$];
    logic [UPD_W-1:0] pend[$];
    logic [CNT_W-1:0] model_cnt = '0;
    bit               flush_pend = 0;
    int               flush_cyc  = 0;
    int               last_take  = 0;
    bit               took_after = 0;
    bit               hold       = 0;
    logic [BW-1:0]    hold_word;
    logic [LANES-1:0] hold_mask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic void close_group();
        beat_t b;
        b.word = '1;
        b.mask = '0;
        foreach (pend[i]) begin
            b.word[i*UPD_W +: UPD_W] = pend[i];
            b.mask[i]                = 1'b1;
        end
        exp_q.push_back(b);
        pend.delete();
    endfunction

    function automatic void model_accept(input logic [UPD_W-1:0] w);
        bit merged;
        merged = 0;
`ifdef WCC_PACK_COALESCE_EN
        if (pend.size() > 0) begin
            wcc_upd_t last, cur;
            last = wcc_upd_t'(pend[pend.size()-1]);
            cur  = wcc_upd_t'(w);
            if (last.dest == cur.dest) begin
                if (cur.value < last.value) last.value = cur.value;
                pend[pend.size()-1] = last;
                merged = 1;
            end
        end
`endif
        if (!merged) begin
            pend.push_back(w);
            if (pend.size() == LANES) close_group();
        end
        if (model_cnt != '1) model_cnt = model_cnt + 1;
    endfunction

    // Monitor: everything observed mid-cycle, when inputs and outputs are settled
    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            exp_q.delete();
            model_cnt  = '0;
            flush_pend = 0;
            hold       = 0;
        end else begin
            chk("upd_count", BW'(bus.upd_count), BW'(model_cnt));
            if (hold) begin
                chk("hold_valid", BW'(bus.out_valid), BW'(1));
                chk("hold_word", bus.out_word, hold_word);
                chk("hold_mask", BW'(bus.out_lane_mask), BW'(hold_mask));
            end
            hold      = bus.out_valid && !bus.out_ready;
            hold_word = bus.out_word;
            hold_mask = bus.out_lane_mask;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_word", bus.out_word, e.word);
                    chk("beat_mask", BW'(bus.out_lane_mask), BW'(e.mask));
                end
                if (flush_pend && cyc > flush_cyc) took_after = 1;
                last_take = cyc;
            end
            if (bus.flush_done) begin
                chk("flush_done_expected", BW'(flush_pend), BW'(1));
                chk("flush_drained", BW'(exp_q.size()), BW'(0));
                if (took_after) chk("flush_done_after_take", BW'(cyc - last_take), BW'(1));
                else            chk("flush_done_latency", BW'(cyc - flush_cyc), BW'(2));
                flush_pend = 0;
            end
            if (bus.update_valid && bus.update_ready) model_accept(bus.update_word);
            if (bus.flush && !flush_pend) begin
                flush_pend = 1;
                flush_cyc  = cyc;
                took_after = 0;
                if (pend.size() > 0) close_group();
            end
        end
    end

    function automatic logic [UPD_W-1:0] mk(input logic [31:0] v, input logic [31:0] d);
        wcc_upd_t u;
        u.value = v;
        u.dest  = d;
        return u;
    endfunction

    // Present one update; returns one step past the accepting edge, valid still high
    task automatic send(input logic [UPD_W-1:0] w, output int waits);
        bit got;
        got = 0;
        waits = 0;
        bus.update_valid = 1'b1;
        bus.update_word  = w;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.update_ready) got = 1;
            else waits++;
        end
        if (!got) fail_now("send_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [31:0] v, input int d0, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            send(mk(v, 32'(d0 + i)), w);
            stalls += w;
        end
        bus.update_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            if (!flush_pend && exp_q.size() == 0 && !bus.out_valid) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) fail_now("idle_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int w;
        bus.update_valid = 1'b0;
        bus.update_word  = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_update_ready", BW'(bus.update_ready), BW'(0));
        chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("rst_mask", BW'(bus.out_lane_mask), BW'(0));
        chk("rst_word", bus.out_word, {BW{1'b1}});
        chk("rst_upd_count", BW'(bus.upd_count), BW'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Full beat at full throughput, latency 2 after last accept
        bus.out_ready = 1'b1;
        send_n(8, 32'd5, 0, st);
        chk("t1_no_stall", BW'(st), BW'(0));
        @(negedge clk);
        chk("t1_valid_t1", BW'(bus.out_valid), BW'(0));
        @(negedge clk);
        chk("t1_valid_t2", BW'(bus.out_valid), BW'(1));
        @(posedge clk); #1;
        wait_idle();

        // Partial beat through flush
        send_n(3, 32'd11, 20, st);
        do_flush();
        wait_idle();
        chk("t2_count", BW'(bus.upd_count), BW'(11));

        // Back-pressure: two beats buffered, input stalls
        bus.out_ready = 1'b0;
        send_n(16, 32'd100, 40, st);
        @(negedge clk);
        chk("t3_ready_low", BW'(bus.update_ready), BW'(0));
        chk("t3_valid", BW'(bus.out_valid), BW'(1));
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle();

        // Flush with nothing buffered
        do_flush();
        wait_idle();

        // Same-dest pair then flush (merged only when coalescing is built in)
        send(mk(32'd7, 32'd9), w);
        send(mk(32'd3, 32'd9), w);
        bus.update_valid = 1'b0;
        do_flush();
        wait_idle();

        // Update in the flush cycle rides in the flushed beat
        bus.update_valid = 1'b1;
        bus.update_word  = mk(32'd77, 32'd123);
        bus.flush        = 1'b1;
        @(negedge clk);
        chk("t5_flush_accept", BW'(bus.update_ready), BW'(1));
        @(posedge clk); #1;
        bus.update_valid = 1'b0;
        bus.flush        = 1'b0;
        wait_idle();

        // Reset in the middle of a fill
        send_n(5, 32'd9, 60, st);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", BW'(bus.update_ready), BW'(0));
        chk("t6_rst_count", BW'(bus.upd_count), BW'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_valid", BW'(bus.out_valid), BW'(0));
        end
        @(posedge clk); #1;
        send_n(8, 32'd1, 70, st);
        wait_idle();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.update_valid = ($urandom_range(0, 99) < 60);
            bus.update_word  = mk($urandom, 32'($urandom_range(0, 3)));
            bus.out_ready    = ($urandom_range(0, 99) < 70);
            bus.flush        = !flush_pend && ($urandom_range(0, 99) < 4);
            @(posedge clk); #1;
        end
        bus.update_valid = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;
        wait_idle();
        do_flush();
        wait_idle();
        chk("end_pending", BW'(pend.size()), BW'(0));
        chk("end_expected", BW'(exp_q.size()), BW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
